// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port sequencer for a shared memory; define MEM_ARB_ROUND_ROBIN_EN for alternating
// arbitration on simultaneous requests, otherwise port 1 (load/store) always has priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_done,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read_write,
  output logic                  mem_enable,
  output logic                  mem_output_en,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;
  state_t state, state_n;
  logic win, grant, sel_we, lat_win, drive;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CW-1:0] cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;
  assign win = (p0_req && p1_req) ? !last_grant : p1_req;
`else
  assign win = p1_req;
`endif
  assign grant  = !reset && state == IDLE && (p0_req || p1_req);
  assign sel_we = win ? p1_we : p0_we;
  // Arbiter owns the bus only during the command cycle of a write
  assign mem_data = drive ? lat_wdata : 'z;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (grant ? CMD : IDLE) :
              state == CMD  ? (mem_read_write ? DONE : WAIT) :
              state == WAIT ? (cnt == CW'(READ_LATENCY - 1) ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    p0_gnt  = grant && !win;
    p1_gnt  = grant && win;
    p0_done = state == DONE && !lat_win;
    p1_done = state == DONE && lat_win;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address    <= '0;
      mem_read_write <= 1'b0;
      mem_enable     <= 1'b0;
      mem_output_en  <= 1'b0;
      drive          <= 1'b0;
      rsp_data       <= '0;
      lat_win        <= 1'b0;
      lat_wdata      <= '0;
      cnt            <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      if (grant) begin
        lat_win        <= win;
        mem_address    <= win ? p1_addr : p0_addr;
        mem_read_write <= sel_we;
        lat_wdata      <= win ? p1_wdata : p0_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant     <= win;
`endif
      end
      mem_enable    <= grant;
      drive         <= grant && sel_we;
      mem_output_en <= grant ? !sel_we :
                       (state == CMD && !mem_read_write) || (state == WAIT && state_n == WAIT);
      cnt           <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == WAIT && state_n == DONE) rsp_data <= mem_data;
    end
  end
endmodule
